aux_int_ctrl: RTL and testbench
===============================

AUX_INT_CTRL -- requirements
Module: aux_int_ctrl

Interface
REQ-001 Parameter NumSrc, default 3, SHALL set the number of interrupt sources; source i has priority i, and the highest index wins.
REQ-002 Parameter MaskInit, default all-zero, SHALL set the reset value of mask; a mask bit of 1 disables that source.
REQ-003 clk  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 en  in  1  SHALL be the core enable; when 0, the FSM, isr and counter are frozen and ack/eret are ignored.
REQ-006 irq_raw  in  NumSrc  SHALL carry the asynchronous active-high interrupt lines, one per source.
REQ-007 mask_we  in  1  SHALL write mask_wdata into mask on the next edge, independent of en.
REQ-008 mask_wdata  in  NumSrc  SHALL be the mask write data.
REQ-009 irq_ack  in  1  SHALL be the core's pulse accepting the presented interrupt.
REQ-010 irq_eret  in  1  SHALL be the core's pulse returning from the current handler.
REQ-011 irq_req  out  1  SHALL request an interrupt from the core.
REQ-012 irq_id  out  clog2(NumSrc)  SHALL identify the requested source; it is stable while irq_req=1.
REQ-013 mask, pending, isr  out  NumSrc each  SHALL expose the current mask, the pending latches and the in-service bits.
REQ-014 eret_err  out  1  SHALL be a sticky flag that is set by an invalid eret.
REQ-015 ack_cnt  out  32  SHALL count accepted interrupts.

Function
REQ-016 Each irq_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) and then a third flop s3; edge[i] = s2[i] & ~s3[i].
REQ-017 pending[i] SHALL set on edge[i] regardless of en or mask; masked sources stay pending.
REQ-018 Level is the index of the highest set isr bit, or -1 if isr=0; eligible = pending & ~mask & {index > level}.
REQ-019 The FSM SHALL have two states, IDLE and REQ; irq_req=1 exactly in REQ.
REQ-020 IDLE->REQ SHALL occur on an edge where en=1 and eligible!=0; irq_id latches the highest eligible index on the same edge.
REQ-021 In REQ, irq_id SHALL NOT change; the request is never withdrawn, even if the source becomes masked or a higher-priority edge arrives.
REQ-022 REQ->IDLE SHALL occur on an edge with en=1 and irq_ack=1; on that edge pending[irq_id] clears, isr[irq_id] sets, and ack_cnt increments with wrap-around.
REQ-023 irq_ack received in IDLE SHALL be ignored.
REQ-024 irq_eret with en=1 SHALL clear the highest set isr bit; if isr=0 it sets eret_err and nothing else changes.
REQ-025 If ack and eret arrive together, the eret SHALL act on isr as it was before the ack, and the ack set SHALL then apply; both take effect on the same edge.
REQ-026 If edge[i] coincides with an ack clearing pending[i], pending[i] SHALL remain 1, because the new event wins.
REQ-027 Latency: if irq_raw[i] rises before edge k, pending[i]=1 after edge k+2 and irq_req=1 after edge k+3, provided the source is eligible and en=1.
REQ-028 The minimum gap from ack to the next irq_req SHALL be 1 cycle; the controller is in IDLE for at least one cycle between requests.
REQ-029 Nesting: a source of higher priority than level SHALL preempt; equal or lower priority waits until eret lowers level.

Reset
REQ-030 While rst_n=0, outputs SHALL be: irq_req=0, irq_id=0, pending=0, isr=0, mask=MaskInit, eret_err=0, ack_cnt=0, synchronizer flops 0, FSM=IDLE.
REQ-031 Reset asserted mid-handshake SHALL abort immediately; after release, only new rising edges are captured.
REQ-032 A line held high across reset release SHALL register one edge 2 cycles after release.

Verification
REQ-033 Single source: pulse irq_raw[0] -> pending=001 after 3 edges, irq_req=1 with irq_id=0 one edge later; ack -> isr=001, pending=000, ack_cnt=1.
REQ-034 Priority: raise sources 0 and 2 in the same cycle -> irq_id=2; ack, then irq_req again with irq_id=0 is withheld (level 2); eret -> isr=000, then irq_id=0 is requested.
REQ-035 Preemption: isr=001 with source 1 pending -> request id 1, ack -> isr=011; eret -> isr=001; eret -> isr=000.
REQ-036 Mask: mask=100, edge on source 2 -> pending=100, no irq_req; write mask=000 -> irq_req=1 with irq_id=2 two edges later.
REQ-037 Corner cases: eret with isr=0 -> eret_err=1 sticky; en=0 during REQ with ack=1 -> no state change; edge coincident with ack of the same source -> pending bit stays 1.
REQ-038 Reset: assert rst_n=0 while in REQ -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/aux_int_ctrl.sv
// aux_int_ctrl: prioritised, nestable interrupt controller with edge capture, masking and ack/eret handshake.
module aux_int_ctrl #(
  parameter int NumSrc = 3,
  parameter logic [NumSrc-1:0] MaskInit = '0,
  localparam int IdW = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NumSrc-1:0] irq_raw,
  input  logic              mask_we,
  input  logic [NumSrc-1:0] mask_wdata,
  input  logic              irq_ack,
  input  logic              irq_eret,
  output logic              irq_req,
  output logic [IdW-1:0]    irq_id,
  output logic [NumSrc-1:0] mask,
  output logic [NumSrc-1:0] pending,
  output logic [NumSrc-1:0] isr,
  output logic              eret_err,
  output logic [31:0]       ack_cnt
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [NumSrc-1:0] s1_q, s2_q, s3_q;
  logic [NumSrc-1:0] mask_q, mask_d, pending_q, pending_d, isr_q, isr_d;
  logic [IdW-1:0] id_q, id_d, hi_id;
  logic err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [NumSrc-1:0] edg, elig, top, sel;
  logic blk;
  always_comb begin
    edg = s2_q & ~s3_q;
    blk = 1'b0;
    elig = '0;
    top = '0;
    sel = '0;
    hi_id = '0;
    // A source is eligible only if no in-service bit sits at its own index or above.
    for (int i = NumSrc - 1; i >= 0; i--) begin
      blk = blk | isr_q[i];
      elig[i] = pending_q[i] & ~mask_q[i] & ~blk;
    end
    for (int i = 0; i < NumSrc; i++) begin
      if (elig[i]) hi_id = IdW'(i);
      if (isr_q[i]) top = NumSrc'(1) << i;
      sel[i] = (id_q == IdW'(i));
    end
    state_d = state_q;
    id_d = id_q;
    pending_d = pending_q | edg;
    isr_d = isr_q;
    err_d = err_q;
    cnt_d = cnt_q;
    mask_d = mask_we ? mask_wdata : mask_q;
    if (en) begin
      if (irq_eret) begin
        err_d = err_q | (isr_q == '0);
        isr_d = isr_q & ~top;
      end
      if (state_q == IDLE && |elig) begin
        state_d = REQ;
        id_d = hi_id;
      end
      // Ack applies after any same-cycle eret; a new edge re-sets the cleared pending bit.
      if (state_q == REQ && irq_ack) begin
        state_d = IDLE;
        pending_d = (pending_q & ~sel) | edg;
        isr_d = isr_d | sel;
        cnt_d = cnt_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      mask_q <= MaskInit;
      pending_q <= '0;
      isr_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= irq_raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
      mask_q <= mask_d;
      pending_q <= pending_d;
      isr_q <= isr_d;
      id_q <= id_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign irq_req = (state_q == REQ);
  assign irq_id = id_q;
  assign mask = mask_q;
  assign pending = pending_q;
  assign isr = isr_q;
  assign eret_err = err_q;
  assign ack_cnt = cnt_q;
endmodule

// File: tb/tb_aux_int_ctrl.sv
// tb_aux_int_ctrl: directed vectors with hand-computed expectations for aux_int_ctrl.
module tb_aux_int_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [2:0] irq_raw = '0, mask_wdata = '0;
  logic mask_we = 1'b0, irq_ack = 1'b0, irq_eret = 1'b0;
  logic irq_req, eret_err;
  logic [1:0] irq_id;
  logic [2:0] mask, pending, isr;
  logic [31:0] ack_cnt;
  int n_tests = 0, n_fail = 0;
  aux_int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_raw(irq_raw), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_ack(irq_ack), .irq_eret(irq_eret), .irq_req(irq_req),
    .irq_id(irq_id), .mask(mask), .pending(pending), .isr(isr), .eret_err(eret_err),
    .ack_cnt(ack_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic [2:0] src);
    irq_raw = src;
    tick();
    irq_raw = '0;
  endtask
  task automatic ack_pulse(input logic eret);
    irq_ack = 1'b1;
    irq_eret = eret;
    tick();
    irq_ack = 1'b0;
    irq_eret = 1'b0;
  endtask
  task automatic eret_pulse();
    irq_eret = 1'b1;
    tick();
    irq_eret = 1'b0;
  endtask
  initial begin
    tick(2);
    check("rst_req", irq_req, 0);
    check("rst_pend", pending, 0);
    check("rst_mask", mask, 0);
    check("rst_cnt", ack_cnt, 0);
    rst_n = 1'b1;
    tick();
    // single source
    pulse(3'b001);
    tick();
    check("s_pend_early", pending, 0);
    tick();
    check("s_pend", pending, 3'b001);
    check("s_req_early", irq_req, 0);
    tick();
    check("s_req", irq_req, 1);
    check("s_id", irq_id, 0);
    ack_pulse(1'b0);
    check("s_isr", isr, 3'b001);
    check("s_pend_clr", pending, 0);
    check("s_cnt", ack_cnt, 1);
    check("s_req_off", irq_req, 0);
    eret_pulse();
    check("s_eret", isr, 0);
    // priority
    pulse(3'b101);
    tick(2);
    check("p_pend", pending, 3'b101);
    tick();
    check("p_req", irq_req, 1);
    check("p_id", irq_id, 2);
    ack_pulse(1'b0);
    check("p_isr", isr, 3'b100);
    check("p_pend2", pending, 3'b001);
    tick(2);
    check("p_withheld", irq_req, 0);
    eret_pulse();
    check("p_eret", isr, 0);
    tick();
    check("p_req0", irq_req, 1);
    check("p_id0", irq_id, 0);
    ack_pulse(1'b0);
    check("p_isr0", isr, 3'b001);
    check("p_cnt", ack_cnt, 3);
    // preemption
    pulse(3'b010);
    tick(3);
    check("n_req", irq_req, 1);
    check("n_id", irq_id, 1);
    ack_pulse(1'b0);
    check("n_isr", isr, 3'b011);
    eret_pulse();
    check("n_eret1", isr, 3'b001);
    eret_pulse();
    check("n_eret2", isr, 0);
    // mask, then en=0 freeze
    mask_we = 1'b1;
    mask_wdata = 3'b100;
    tick();
    mask_we = 1'b0;
    check("m_mask", mask, 3'b100);
    pulse(3'b100);
    tick(3);
    check("m_pend", pending, 3'b100);
    check("m_noreq", irq_req, 0);
    mask_we = 1'b1;
    mask_wdata = 3'b000;
    tick();
    mask_we = 1'b0;
    check("m_req_early", irq_req, 0);
    tick();
    check("m_req", irq_req, 1);
    check("m_id", irq_id, 2);
    en = 1'b0;
    ack_pulse(1'b0);
    en = 1'b1;
    check("e_req", irq_req, 1);
    check("e_isr", isr, 0);
    check("e_cnt", ack_cnt, 4);
    ack_pulse(1'b0);
    check("e_isr2", isr, 3'b100);
    check("e_cnt2", ack_cnt, 5);
    eret_pulse();
    // invalid eret
    check("x_err0", eret_err, 0);
    eret_pulse();
    check("x_err", eret_err, 1);
    check("x_isr", isr, 0);
    tick(2);
    check("x_sticky", eret_err, 1);
    // edge coincident with ack of same source
    irq_raw = 3'b010;
    tick();
    irq_raw = '0;
    tick();
    irq_raw = 3'b010;
    tick();
    irq_raw = '0;
    check("c_pend", pending, 3'b010);
    tick();
    check("c_req", irq_req, 1);
    check("c_id", irq_id, 1);
    ack_pulse(1'b0);
    check("c_pend_kept", pending, 3'b010);
    check("c_isr", isr, 3'b010);
    check("c_cnt", ack_cnt, 6);
    tick();
    check("c_equal_wait", irq_req, 0);
    eret_pulse();
    tick();
    check("c_req2", irq_req, 1);
    ack_pulse(1'b0);
    check("c_pend_clr", pending, 0);
    eret_pulse();
    // ack and eret together
    pulse(3'b001);
    tick(3);
    ack_pulse(1'b0);
    pulse(3'b100);
    tick(3);
    check("a_id", irq_id, 2);
    ack_pulse(1'b1);
    check("a_isr", isr, 3'b100);
    check("a_cnt", ack_cnt, 9);
    eret_pulse();
    // async reset while in REQ, line held high across release
    pulse(3'b001);
    tick(3);
    check("r_req_pre", irq_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_req", irq_req, 0);
    check("r_pend", pending, 0);
    check("r_isr", isr, 0);
    check("r_err", eret_err, 0);
    check("r_cnt", ack_cnt, 0);
    irq_raw = 3'b100;
    tick();
    rst_n = 1'b1;
    tick(2);
    check("h_pend_early", pending, 0);
    tick();
    check("h_pend", pending, 3'b100);
    tick();
    check("h_id", irq_id, 2);
    ack_pulse(1'b0);
    tick(4);
    check("h_once", pending, 0);
    check("h_noreq", irq_req, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
